// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch stage and the control logic
// that consumes its instructions.
//   - opcode constants (instr[15:11])
//   - canonical NOP instruction word
//   - fetch FSM state encoding
//   - opcode extraction helper
package fetch_pkg;

  // Opcodes in instr[15:11], shared with the control stage.
  localparam logic [4:0] OPC_HALT = 5'b00000;
  localparam logic [4:0] OPC_NOP  = 5'b00001;
  localparam logic [4:0] OPC_BEQ  = 5'b10000;
  localparam logic [4:0] OPC_BNE  = 5'b10001;
  localparam logic [4:0] OPC_J    = 5'b11000;
  localparam logic [4:0] OPC_JAL  = 5'b11001;
  localparam logic [4:0] OPC_JR   = 5'b11010;
  localparam logic [4:0] OPC_JALR = 5'b11011;

  // NOP with all operand fields zero.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  // Fetch FSM: ISSUE sends a request, WAIT holds until the read returns,
  // HALTED parks after a HALT has been buffered.
  typedef enum logic [1:0] {
    FS_ISSUE  = 2'd0,
    FS_WAIT   = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [4:0] opcode_of(input logic [15:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: single-entry valid/ready holding register.
// Used as the fetch output buffer and later as the IF/ID pipeline register.
//   clk, rst   : clock, synchronous active-high reset
//   fill       : load fill_data/fill_tag and mark valid
//   flush      : drop the entry (wins over fill and drain)
//   drain      : consumer ready; a transfer is valid & drain
//   valid/data/tag : held entry, stable while valid & !drain
//   free       : entry can accept a fill this cycle (empty or draining)
module fetch_buf #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic              flush,
  input  logic              drain,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [TAG_W-1:0]  fill_tag,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [TAG_W-1:0]  tag,
  output logic              free
);

  assign free = ~valid | drain;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the payload registers are reset as well as valid, so the outputs
  // read as zero after reset rather than as leftover data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      tag   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (fill) begin
      // A fill during a transfer overwrites the entry and stays valid.
      valid <= 1'b1;
      data  <= fill_data;
      tag   <= fill_tag;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch. Owns the PC, issues one outstanding read
// at a time to instruction memory, and buffers the returned instruction
// (with its PC+2) for decode through a valid/ready handshake.
//   clk, rst          : clock, synchronous active-high reset
//   imem_req/addr     : one-cycle read request and its address
//   imem_ack/rdata    : read data return, at least one cycle after request
//   redirect_valid/pc : PC change from execute (highest priority)
//   if_valid/instr/pc_plus2, dec_ready : output handshake to decode
//   halted            : a HALT has been buffered and fetch is parked
//   err               : pulse on an ack with no request outstanding
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [4:0]      OP_HALT  = OPC_HALT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            dec_ready,
  output logic [15:0]     if_instr,
  output logic [PC_W-1:0] if_pc_plus2,
  output logic            halted,
  output logic            err
);

  fetch_state_e    state, state_n;
  logic [PC_W-1:0] pc, pc_n, pc_plus2;
  logic            squash, squash_n;
  logic            halted_n;
  logic            buf_fill, buf_flush, buf_free;

  // Wraps modulo 2^PC_W.
  assign pc_plus2  = pc + PC_W'(2);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FS_ISSUE;
      pc     <= RESET_PC;
      squash <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      squash <= squash_n;
      halted <= halted_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    squash_n  = squash;
    halted_n  = halted;
    buf_fill  = 1'b0;
    buf_flush = 1'b0;
    imem_req  = 1'b0;
    err       = 1'b0;

    // Redirect overrides everything: new PC, buffer flushed, halt cleared.
    if (redirect_valid) begin
      pc_n      = redirect_pc;
      buf_flush = 1'b1;
      halted_n  = 1'b0;
    end

    case (state)
      FS_ISSUE: begin
        err = imem_ack;
        if (!redirect_valid && buf_free) begin
          imem_req = 1'b1;
          state_n  = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_ack) begin
          state_n  = FS_ISSUE;
          squash_n = 1'b0;
          // Data belonging to a redirected-away path is dropped.
          if (!redirect_valid && !squash) begin
            buf_fill = 1'b1;
            pc_n     = pc_plus2;
            if (opcode_of(imem_rdata) == OP_HALT) begin
              halted_n = 1'b1;
              state_n  = FS_HALTED;
            end
          end
        end else if (redirect_valid) begin
          // The read is still in flight; remember to drop its data.
          squash_n = 1'b1;
        end
      end
      FS_HALTED: begin
        err = imem_ack;
        if (redirect_valid) state_n = FS_ISSUE;
      end
      default: state_n = FS_ISSUE;
    endcase

    if (rst) begin
      imem_req = 1'b0;
      err      = 1'b0;
    end
  end

  fetch_buf #(
    .DATA_W (16),
    .TAG_W  (PC_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .fill      (buf_fill),
    .flush     (buf_flush),
    .drain     (dec_ready),
    .fill_data (imem_rdata),
    .fill_tag  (pc_plus2),
    .valid     (if_valid),
    .data      (if_instr),
    .tag       (if_pc_plus2),
    .free      (buf_free)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a cycle-stepped instruction memory model with
// configurable latency, a table of directed vectors for steady-state fetch
// and back-pressure, and hand-written sequences for redirect, halt, PC
// wrap-around, spurious ack and mid-read reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic        dec_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic        halted;
  logic        err;

  always #5 clk = ~clk;

  fetch_stage #(
    .PC_W     (16),
    .RESET_PC (16'h0000),
    .OP_HALT  (5'b00000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .dec_ready      (dec_ready),
    .if_instr       (if_instr),
    .if_pc_plus2    (if_pc_plus2),
    .halted         (halted),
    .err            (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model state.
  int          cyc       = 0;
  int          last_cyc  = 0;
  bit          pend      = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  int          ack_cycle = 0;
  int          lat       = 1;
  logic [15:0] halt_addr = 16'h0010;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'h0000;
    if (a <= 16'h0004)  return 16'h4005;
    return {5'b00010, a[10:0]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, last_cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, let memory respond,
  // then record any request the DUT raises. Outputs stay stable until the
  // next rising edge, so checks after tick() see this cycle's values.
  task automatic tick(input logic r, input logic rv, input logic [15:0] rpc,
                      input logic dr, input logic spur);
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = dr;
    imem_ack       = 1'b0;
    imem_rdata     = 16'h0000;
    if (pend && cyc == ack_cycle) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(pend_addr);
      pend       = 1'b0;
    end else if (spur) begin
      imem_ack   = 1'b1;
      imem_rdata = 16'hDEAD;
    end
    #1;
    if (r) begin
      pend = 1'b0;
    end else if (imem_req) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      ack_cycle = cyc + lat;
    end
    last_cyc = cyc;
    cyc++;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [15:0] addr,
                            input logic valid, input logic [15:0] instr,
                            input logic [15:0] pc2, input logic hlt, input logic e);
    check({tag, ".req"}, 16'(imem_req), 16'(req));
    if (req) check({tag, ".addr"}, imem_addr, addr);
    check({tag, ".valid"}, 16'(if_valid), 16'(valid));
    if (valid) begin
      check({tag, ".instr"}, if_instr, instr);
      check({tag, ".pc_plus2"}, if_pc_plus2, pc2);
    end
    check({tag, ".halted"}, 16'(halted), 16'(hlt));
    check({tag, ".err"}, 16'(err), 16'(e));
  endtask

  typedef struct {
    logic        dr;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc2;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Steady fetch with 1-cycle memory, then 5 cycles of back-pressure.
    //           dr    req   addr      valid instr     pc2
    vecs[0]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h4005, 16'h0002};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h4005, 16'h0004};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4005, 16'h0006};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4005, 16'h0006};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4005, 16'h0006};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4005, 16'h0006};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4005, 16'h0006};
    vecs[11] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h4005, 16'h0006};
    vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[13] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h1006, 16'h0008};

    rst            = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = 16'h0000;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    dec_ready      = 1'b1;

    // Reset values.
    tick(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("reset.instr", if_instr, 16'h0000);
    check("reset.pc_plus2", if_pc_plus2, 16'h0000);

    cyc = 0;
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, 1'b0, 16'h0000, vecs[i].dr, 1'b0);
      expect_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                 vecs[i].instr, vecs[i].pc2, 1'b0, 1'b0);
    end

    // Redirect while waiting; the late ack must be discarded.
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("c14", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    lat = 3;
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("c15", 1'b1, 16'h000A, 1'b1, 16'h1008, 16'h000A, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 16'h0100, 1'b1, 1'b0);
    expect_out("redir_wait", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    lat = 1;
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("squash_wait", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("squash_ack", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("after_squash", 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("c20", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Redirect in ISSUE with a full buffer and dec_ready=1: flushed, no request.
    tick(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0);
    expect_out("redir_issue", 1'b0, 16'h0000, 1'b1, 16'h1100, 16'h0102, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("flushed", 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("c23", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // HALT buffered: no further requests, drains, redirect leaves HALTED.
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    expect_out("halt_hold", 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0012, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("halt_drain", 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0012, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("halt_empty", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0);
    expect_out("halt_redir", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("unhalted", 1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("c29", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // PC wrap-around at 16'hFFFE.
    tick(1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    expect_out("redir_fffe", 1'b0, 16'h0000, 1'b1, 16'h1020, 16'h0022, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("issue_fffe", 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("c32", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("wrap", 1'b1, 16'h0000, 1'b1, 16'h17FE, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("c34", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Spurious ack in ISSUE (held by back-pressure): err pulses, state kept.
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    expect_out("spur", 1'b0, 16'h0000, 1'b1, 16'h4005, 16'h0002, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    expect_out("spur_after", 1'b0, 16'h0000, 1'b1, 16'h4005, 16'h0002, 1'b0, 1'b0);
    lat = 3;
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("spur_resume", 1'b1, 16'h0002, 1'b1, 16'h4005, 16'h0002, 1'b0, 1'b0);

    // Reset in the middle of a read; memory is reset too, so no stale ack.
    tick(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("rst_wait", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("post_rst", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("c40", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("c41", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("c42", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("post_rst_fill", 1'b1, 16'h0002, 1'b1, 16'h4005, 16'h0002, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the PC, issues one-outstanding reads to instruction memory, and buffers the returned 16-bit instruction for the decode/control stage through a valid/ready handshake.
- Handles redirects (branch taken, J/JR/JAL/JALR) from execute, and stops fetching after delivering a HALT opcode.
- Supplies PC+2 alongside each instruction for link and branch-offset arithmetic downstream.

Parameters:
- PC_W, 16, PC and address width
- RESET_PC, 16'h0000, PC loaded on reset
- OP_HALT, 5'b00000, opcode in instr[15:11] that stops fetch

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  one-cycle read request pulse
- imem_addr  out  PC_W  read address; valid while imem_req=1
- imem_ack  in  1  read data valid; arrives ≥1 cycle after imem_req
- imem_rdata  in  16  instruction word; valid with imem_ack
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  PC_W  new fetch target
- if_valid  out  1  if_instr/if_pc_plus2 hold a valid instruction
- dec_ready  in  1  decode accepts this cycle; transfer = if_valid & dec_ready
- if_instr  out  16  buffered instruction
- if_pc_plus2  out  PC_W  address of buffered instruction + 2
- halted  out  1  HALT delivered to buffer; fetch stopped
- err  out  1  one-cycle pulse: imem_ack received with no request outstanding

Behaviour:
- Clock/reset: single clock; reset synchronous, active-high, applied only at posedge clk.
- Reset values: pc=RESET_PC; state=ISSUE; if_valid=0; if_instr=16'h0000; if_pc_plus2=0; halted=0; squash=0; imem_req=0; err=0. Any in-flight memory read is abandoned, and memory is reset together with this block.
- FSM states: ISSUE, WAIT, HALTED.
- ISSUE:
  - imem_req=1 and imem_addr=pc when redirect_valid=0 and the buffer is free. Free means if_valid=0, or if_valid & dec_ready this cycle.
  - On issue, go to WAIT. Otherwise imem_req=0 and stay in ISSUE.
- WAIT:
  - imem_req=0. On imem_ack with squash=0: if_instr<=imem_rdata, if_pc_plus2<=pc+2, if_valid<=1, pc<=pc+2.
  - If imem_rdata[15:11]==OP_HALT, set halted<=1 and go to HALTED. Otherwise go to ISSUE.
  - On imem_ack with squash=1: discard the data, clear squash, go to ISSUE.
- HALTED:
  - No requests issued; the buffered HALT still drains via the handshake.
  - Only a redirect or reset leaves this state.
- Redirect (highest priority, any state):
  - pc<=redirect_pc; if_valid<=0 (buffer flushed even if dec_ready=1 that cycle; no transfer counts); halted<=0.
  - ISSUE: no request that cycle; stay in ISSUE.
  - WAIT without imem_ack: squash<=1; stay in WAIT.
  - WAIT with imem_ack the same cycle: data discarded; go to ISSUE.
  - HALTED: go to ISSUE.
- Handshake:
  - While if_valid=1 and dec_ready=0, if_instr and if_pc_plus2 are held stable.
  - A transfer without a simultaneous fill clears if_valid.
  - A fill in the same cycle as a transfer overwrites the buffer and keeps if_valid=1.
- Arithmetic: pc+2 is modulo 2^PC_W (16'hFFFE+2 = 16'h0000). Bit 0 of redirect_pc is passed through unchanged.
- Latency: with 1-cycle memory and dec_ready=1, one instruction every 2 cycles. Request to if_valid is 2 cycles.
- err: pulses for one cycle when imem_ack=1 in ISSUE or HALTED. The data is ignored and the state is unchanged.

Decomposition:
- Shared package holds:
  - opcode constants (OP_HALT, OP_NOP=5'b00001, jump/branch opcodes shared with control)
  - NOP_INSTR=16'h0800
  - fetch FSM state encoding
- One sub-module, fetch_buf: single-entry valid/ready holding register with fill, flush and drain inputs. Reused later as the IF/ID pipeline register.

Test Plan:
- Reset, dec_ready=1, 1-cycle memory returning 16'h4005 at addresses 0,2,4 → imem_addr 0,2,4 on successive issues; if_pc_plus2 2,4,6; if_valid first high at cycle 2 after reset release.
- dec_ready=0 for 5 cycles after the first fill → if_instr stable, imem_req stays 0. Raising dec_ready → transfer, and the next request is issued in the same cycle.
- Redirect to 16'h0100 in WAIT with the ack 2 cycles later → that returned word is discarded, if_valid=0, next imem_addr=16'h0100.
- Fetch 16'h0000 (HALT) at pc 16'h0010 → if_instr=16'h0000, if_pc_plus2=16'h0012, halted=1, no further imem_req. Redirect to 16'h0020 → halted=0, imem_addr=16'h0020.
- pc=16'hFFFE fetch → if_pc_plus2=16'h0000, next imem_addr=16'h0000. Spurious imem_ack in ISSUE → err pulses once, state unchanged.
- Assert rst mid-WAIT → next cycle imem_req=1, imem_addr=RESET_PC, if_valid=0; a stale ack arriving in the WAIT state that follows is accepted only if memory was not reset. The bench resets memory too, so no stale ack appears.
